// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req   : fetch request, held high until imem_valid
//   imem_addr  : word-aligned fetch address
//   imem_valid : imem_rdata carries the requested word this cycle
//   imem_rdata : fetched instruction word
// The fetch unit uses the master modport and the memory uses the slave modport.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. It owns the program counter and issues one request
// at a time to instruction memory. It holds the fetched word until the
// downstream stage retires it, then selects the next PC from PCSrc and ImmExt.
// A misaligned next PC is not fetched. Instead the unit parks in TRAP and
// raises a sticky trap flag until reset.
//
// Ports:
//   clk, rst      : rising-edge clock; synchronous active-high reset
//   imem          : instruction-memory bus (master side)
//   instr_ready   : downstream retires the held instruction this cycle
//   PCSrc, ImmExt : next-PC select and branch/jump offset, sampled on retire
//   Instr         : held instruction register
//   instr_valid   : Instr is valid and awaiting retire
//   PC, PCPlus4   : address of Instr, and that address plus 4
//   op, funct3, funct7_5 : decode fields taken directly from Instr
//   trap          : sticky misaligned-target flag
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_unit_if.master   imem,
  input  logic                 instr_ready,
  input  logic                 PCSrc,
  input  logic [31:0]          ImmExt,
  output logic [31:0]          Instr,
  output logic                 instr_valid,
  output logic [31:0]          PC,
  output logic [31:0]          PCPlus4,
  output logic [6:0]           op,
  output logic [2:0]           funct3,
  output logic                 funct7_5,
  output logic                 trap
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    TRAP
  } state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] next_pc;

  // Both candidate sums wrap modulo 2^32, and the carry is dropped.
  assign PCPlus4 = PC + 32'd4;
  assign next_pc = PCSrc ? (PC + ImmExt) : PCPlus4;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = PC;

  assign op       = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7_5 = Instr[30];

  // imem_req and instr_valid are registered alongside the state, so each one
  // reflects the state the FSM is entering at this edge.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the order of statements in this block does not change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      Instr       <= NOP_INSTR;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      trap        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_valid) begin
            Instr       <= imem.imem_rdata;
            state       <= HOLD;
            req_q       <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              PC    <= next_pc;
              state <= FETCH;
              req_q <= 1'b1;
            end else begin
              // Keep the PC of the offending instruction for inspection.
              trap  <= 1'b1;
              state <= TRAP;
            end
          end
        end
        TRAP: begin
          // Only rst leaves TRAP.
          state <= TRAP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_ready = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] ImmExt = 32'h0;
  logic [31:0] Instr, PC, PCPlus4;
  logic        instr_valid, funct7_5, trap;
  logic [6:0]  op;
  logic [2:0]  funct3;

  // Memory model: imem_valid is asserted after wait_cycles of waiting, and
  // zero wait means the same cycle as the request. force_valid injects a
  // stray response with distinctive data.
  int          wait_cycles = 0;
  int          wait_cnt;
  logic        force_valid = 1'b0;

  // Second instance, used for the PC wrap-around scenario.
  logic        ready2 = 1'b0;
  logic [31:0] w_instr, w_pc, w_pcplus4;
  logic        w_valid, w_f75, w_trap;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit_if mem_if ();
  instr_fetch_unit_if wrap_if ();

  always #5 clk = ~clk;

  assign mem_if.imem_valid = force_valid | (mem_if.imem_req && (wait_cnt >= wait_cycles));
  assign mem_if.imem_rdata = force_valid ? 32'hDEAD_BEEF : (32'h0000_0013 | (mem_if.imem_addr << 10));

  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (mem_if.imem_req && !mem_if.imem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign wrap_if.imem_valid = wrap_if.imem_req;
  assign wrap_if.imem_rdata = 32'h0000_0013;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem(mem_if.master), .instr_ready(instr_ready),
    .PCSrc(PCSrc), .ImmExt(ImmExt), .Instr(Instr), .instr_valid(instr_valid),
    .PC(PC), .PCPlus4(PCPlus4), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .trap(trap)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem(wrap_if.master), .instr_ready(ready2),
    .PCSrc(1'b0), .ImmExt(32'h0), .Instr(w_instr), .instr_valid(w_valid),
    .PC(w_pc), .PCPlus4(w_pcplus4), .op(w_op), .funct3(w_f3), .funct7_5(w_f75),
    .trap(w_trap)
  );

  // Advance one clock. Inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if (PC !== 32'h0) $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); else n_pass++;
    n_checks++; if (Instr !== 32'h13) $display("FAIL reset_instr: got %h expected %h", Instr, 32'h13); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else n_pass++;
    n_checks++; if (mem_if.imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", mem_if.imem_req); else n_pass++;
    n_checks++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b expected 0", trap); else n_pass++;
    n_checks++; if ({op, funct3, funct7_5} !== {7'b0010011, 3'b000, 1'b0}) $display("FAIL reset_fields: got %b %b %b expected 0010011 000 0", op, funct3, funct7_5); else n_pass++;
    rst = 1'b0;
    // Cycle 0 is spent in IDLE and cannot request yet.
    n_checks++; if (mem_if.imem_req !== 1'b0) $display("FAIL idle_req: got %b expected 0", mem_if.imem_req); else n_pass++;
    step();
    n_checks++; if (mem_if.imem_req !== 1'b1) $display("FAIL c1_req: got %b expected 1", mem_if.imem_req); else n_pass++;
    n_checks++; if (mem_if.imem_addr !== 32'h0) $display("FAIL c1_addr: got %h expected %h", mem_if.imem_addr, 32'h0); else n_pass++;
    step();
    n_checks++; if (instr_valid !== 1'b1) $display("FAIL c2_valid: got %b expected 1", instr_valid); else n_pass++;
    n_checks++; if ({op, funct3} !== {7'b0010011, 3'b000}) $display("FAIL c2_fields: got %b %b expected 0010011 000", op, funct3); else n_pass++;
    n_checks++; if (mem_if.imem_req !== 1'b0) $display("FAIL c2_req: got %b expected 0", mem_if.imem_req); else n_pass++;
  endtask

  // The DUT is in HOLD at PC=0. Retire sequentially with 3 wait states per fetch.
  task automatic test_seq_wait();
    logic [31:0] exp_addr [2];
    logic [31:0] exp_old  [2];
    exp_addr[0] = 32'h4; exp_addr[1] = 32'h8;
    exp_old[0]  = 32'h0000_0013; exp_old[1] = 32'h0000_1013;
    wait_cycles = 3;
    PCSrc = 1'b0;
    instr_ready = 1'b1;
    n_checks++; if (PCPlus4 !== 32'h4) $display("FAIL pcplus4: got %h expected %h", PCPlus4, 32'h4); else n_pass++;
    for (int f = 0; f < 2; f++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== exp_addr[f]) $display("FAIL wait_addr f%0d k%0d: got req %b addr %h expected req 1 addr %h", f, k, mem_if.imem_req, mem_if.imem_addr, exp_addr[f]); else n_pass++;
        n_checks++; if (Instr !== exp_old[f] || instr_valid !== 1'b0) $display("FAIL wait_instr f%0d k%0d: got %h valid %b expected %h valid 0", f, k, Instr, instr_valid, exp_old[f]); else n_pass++;
        step();
      end
      n_checks++; if (mem_if.imem_addr !== exp_addr[f]) $display("FAIL last_wait_addr f%0d: got %h expected %h", f, mem_if.imem_addr, exp_addr[f]); else n_pass++;
      step();
      n_checks++; if (Instr !== (32'h13 | (exp_addr[f] << 10)) || instr_valid !== 1'b1) $display("FAIL seq_instr f%0d: got %h valid %b expected %h valid 1", f, Instr, instr_valid, 32'h13 | (exp_addr[f] << 10)); else n_pass++;
    end
    instr_ready = 1'b0;
  endtask

  // The DUT is in HOLD at PC=8. Stall for 5 cycles with a stray imem_valid.
  task automatic test_stall();
    force_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (Instr !== 32'h2013 || PC !== 32'h8) $display("FAIL stall_hold k%0d: got instr %h pc %h expected instr 00002013 pc 00000008", k, Instr, PC); else n_pass++;
      n_checks++; if (mem_if.imem_req !== 1'b0 || instr_valid !== 1'b1) $display("FAIL stall_ctrl k%0d: got req %b valid %b expected req 0 valid 1", k, mem_if.imem_req, instr_valid); else n_pass++;
    end
    force_valid = 1'b0;
  endtask

  // Walk from PC=8 to PC=0x10, then branch back by -8.
  task automatic test_branch();
    wait_cycles = 0;
    instr_ready = 1'b1;
    step(); step(); step(); step();
    n_checks++; if (PC !== 32'h10 || instr_valid !== 1'b1 || Instr !== 32'h4013) $display("FAIL pre_branch: got pc %h valid %b instr %h expected pc 00000010 valid 1 instr 00004013", PC, instr_valid, Instr); else n_pass++;
    PCSrc = 1'b1;
    ImmExt = 32'hFFFF_FFF8;
    step();
    n_checks++; if (mem_if.imem_addr !== 32'h8 || mem_if.imem_req !== 1'b1) $display("FAIL branch_addr: got addr %h req %b expected addr 00000008 req 1", mem_if.imem_addr, mem_if.imem_req); else n_pass++;
    PCSrc = 1'b0;
    instr_ready = 1'b0;
    step();
    n_checks++; if (Instr !== 32'h2013 || PC !== 32'h8) $display("FAIL branch_fetch: got instr %h pc %h expected 00002013 00000008", Instr, PC); else n_pass++;
  endtask

  // The DUT is in HOLD at PC=8. A +2 jump is misaligned and traps.
  task automatic test_misaligned();
    instr_ready = 1'b1;
    PCSrc = 1'b1;
    ImmExt = 32'h2;
    step();
    PCSrc = 1'b0;
    n_checks++; if (trap !== 1'b1 || PC !== 32'h8 || instr_valid !== 1'b0) $display("FAIL trap_enter: got trap %b pc %h valid %b expected 1 00000008 0", trap, PC, instr_valid); else n_pass++;
    force_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (mem_if.imem_req !== 1'b0 || trap !== 1'b1 || PC !== 32'h8 || Instr !== 32'h2013) $display("FAIL trap_stay k%0d: got req %b trap %b pc %h instr %h expected 0 1 00000008 00002013", k, mem_if.imem_req, trap, PC, Instr); else n_pass++;
    end
    force_valid = 1'b0;
    rst = 1'b1;
    step();
    n_checks++; if (trap !== 1'b0 || PC !== 32'h0 || Instr !== 32'h13) $display("FAIL trap_reset: got trap %b pc %h instr %h expected 0 00000000 00000013", trap, PC, Instr); else n_pass++;
    rst = 1'b0;
    instr_ready = 1'b0;
    wait_cycles = 3;
    step();
    n_checks++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== 32'h0) $display("FAIL trap_resume: got req %b addr %h expected 1 00000000", mem_if.imem_req, mem_if.imem_addr); else n_pass++;
  endtask

  // The DUT is in FETCH and waiting. A reset must abandon the fetch.
  task automatic test_reset_mid_fetch();
    step();
    n_checks++; if (mem_if.imem_req !== 1'b1) $display("FAIL midfetch_req: got %b expected 1", mem_if.imem_req); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if (mem_if.imem_req !== 1'b0 || instr_valid !== 1'b0 || Instr !== 32'h13) $display("FAIL midfetch_reset: got req %b valid %b instr %h expected 0 0 00000013", mem_if.imem_req, instr_valid, Instr); else n_pass++;
    rst = 1'b0;
    step();
    n_checks++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== 32'h0) $display("FAIL midfetch_restart: got req %b addr %h expected 1 00000000", mem_if.imem_req, mem_if.imem_addr); else n_pass++;
  endtask

  // Second instance: RESET_PC = FFFF_FFFC, and retiring wraps the PC to 0.
  task automatic test_wrap();
    step();
    n_checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_hold: got valid %b pc %h expected 1 fffffffc", w_valid, w_pc); else n_pass++;
    n_checks++; if (w_pcplus4 !== 32'h0) $display("FAIL wrap_pcplus4: got %h expected 00000000", w_pcplus4); else n_pass++;
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    n_checks++; if (w_pc !== 32'h0 || w_trap !== 1'b0 || wrap_if.imem_addr !== 32'h0 || wrap_if.imem_req !== 1'b1) $display("FAIL wrap_next: got pc %h trap %b addr %h req %b expected 0 0 0 1", w_pc, w_trap, wrap_if.imem_addr, wrap_if.imem_req); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_seq_wait();
    test_stall();
    test_branch();
    test_misaligned();
    test_reset_mid_fetch();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
